// File: rtl/seg_scroll_pkg.sv
// Shared constants and helpers for the N-digit 7-segment text scroller.
// Holds reset/default timing values and the wrapped position step function.
package seg_scroll_pkg;

    localparam int DEF_N_DIGITS  = 4;
    localparam int DEF_LEN_W     = 8;
    localparam int DEF_LEN_MAX   = 255;
    localparam int DEF_SCAN_DIV  = 32767;
    localparam int DEF_STEP_W    = 26;
    localparam int DEF_STEP_INIT = 24000000;
    localparam int DEF_STEP_MIN  = 524287;
    localparam int DEF_BLINK_DIV = 20000000;
    localparam int LEN_RESET     = 16;

    // One step through a circular buffer of length l; dec=1 steps backwards.
    function automatic logic [31:0] wrap_pos(
        input logic [31:0] p,
        input logic [31:0] l,
        input logic        dec
    );
        logic [31:0] r;
        if (dec) begin
            r = (p == 32'd0) ? l - 32'd1 : p - 32'd1;
        end else begin
            r = (p + 32'd1 >= l) ? 32'd0 : p + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scroll_ctrl_scan.sv
// seg_scan_mux: time-multiplexed digit scan for an active-low 7-seg display.
// Ports: clk_i, rst_ni (sync), glyphs_i (8 bits/digit) -> seg_n_o, an_n_o.
module seg_scan_mux
    import seg_scroll_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [8*N_DIGITS-1:0] glyphs_i,
    output logic [7:0]            seg_n_o,
    output logic [N_DIGITS-1:0]   an_n_o
);

    localparam int CNT_W = $clog2(SCAN_DIV + 1);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                wrap;

    // Anode and segment registers both follow the next index, so they
    // switch together with no cycle of mismatched glyph.
    always_comb begin
        wrap  = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d  = ~(N_DIGITS'(1) << idx_d);
        seg_d = ~glyphs_i[{idx_d, 3'b000} +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= 8'hFF;
            an_q  <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg_n_o = seg_q;
    assign an_n_o  = an_q;

endmodule

// File: rtl/seg_scroll_ctrl.sv
// seg_scroll_ctrl: scroll position/length control plus N-digit 7-seg scan.
// Ports: buttons/levels in, glyphs in; pos/len, seg_n/an_n, LEDs out.
// Optional SCROLL_BOUNCE_EN adds input bounce for ping-pong auto-scroll.
module seg_scroll_ctrl
    import seg_scroll_pkg::*;
#(
    parameter int N_DIGITS  = DEF_N_DIGITS,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int LEN_MAX   = DEF_LEN_MAX,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int STEP_INIT = DEF_STEP_INIT,
    parameter int STEP_MIN  = DEF_STEP_MIN,
    parameter int BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause,
    input  logic                  reverse,
    input  logic                  faster,
    input  logic                  slower,
    input  logic                  longer,
    input  logic                  shorter,
`ifdef SCROLL_BOUNCE_EN
    input  logic                  bounce,
`endif
    input  logic [8*N_DIGITS-1:0] glyphs,
    output logic [LEN_W-1:0]      pos,
    output logic [LEN_W-1:0]      len,
    output logic [7:0]            seg_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  pause_led,
    output logic                  reverse_led
);

    localparam int LEN_RST = (LEN_RESET < N_DIGITS) ? N_DIGITS :
                             (LEN_RESET > LEN_MAX)  ? LEN_MAX  : LEN_RESET;
    localparam int BLK_W   = $clog2(BLINK_DIV + 1);

    localparam logic [LEN_W-1:0]  LEN_HI  = LEN_W'(LEN_MAX);
    localparam logic [LEN_W-1:0]  LEN_LO  = LEN_W'(N_DIGITS);
    localparam logic [STEP_W-1:0] STEP_LO = STEP_W'(STEP_MIN);

    logic [3:0]        btn, prev_q, rise_q, rise_d;
    logic              f_rise, s_rise, l_rise, h_rise;
    logic [LEN_W-1:0]  pos_q, pos_d, pos_c, len_q, len_d;
    logic [STEP_W-1:0] intv_q, intv_d, stepc_q, stepc_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              blink_q, blink_d;
    logic              tick, step_dec;

    assign btn = {faster, slower, longer, shorter};
    assign {f_rise, s_rise, l_rise, h_rise} = rise_q;
    assign tick = !pause && (stepc_q >= intv_q);

`ifdef SCROLL_BOUNCE_EN
    logic bnc_prev_q, dir_q, dir_d;

    // reverse seeds the direction when bounce rises; afterwards the
    // direction flips at either end of the visible window.
    always_comb begin
        dir_d    = dir_q;
        step_dec = reverse;
        if (bounce && !bnc_prev_q) begin
            dir_d = reverse;
        end
        if (bounce) begin
            step_dec = dir_d;
            if (tick) begin
                if (!dir_d && pos_c >= len_d - LEN_LO) begin
                    step_dec = 1'b1;
                end else if (dir_d && pos_c == '0) begin
                    step_dec = 1'b0;
                end
                dir_d = step_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bnc_prev_q <= bounce;
            dir_q      <= 1'b0;
        end else begin
            bnc_prev_q <= bounce;
            dir_q      <= dir_d;
        end
    end
`else
    assign step_dec = reverse;
`endif

    always_comb begin
        rise_d = btn & ~prev_q;

        // Length first; both buttons together cancel.
        len_d = len_q;
        if (l_rise && !h_rise && len_q != LEN_HI) begin
            len_d = len_q + 1'b1;
        end else if (h_rise && !l_rise && len_q != LEN_LO) begin
            len_d = len_q - 1'b1;
        end

        // Keep pos inside the new length before stepping from it.
        pos_c = (len_d <= pos_q) ? len_d - 1'b1 : pos_q;

        pos_d = pos_c;
        if (pause) begin
            if (f_rise && !s_rise) begin
                pos_d = LEN_W'(wrap_pos(32'(pos_c), 32'(len_d), 1'b1));
            end else if (s_rise && !f_rise) begin
                pos_d = LEN_W'(wrap_pos(32'(pos_c), 32'(len_d), 1'b0));
            end
        end else if (tick) begin
            pos_d = LEN_W'(wrap_pos(32'(pos_c), 32'(len_d), step_dec));
        end

        stepc_d = stepc_q;
        if (!pause) begin
            stepc_d = tick ? '0 : stepc_q + 1'b1;
        end

        intv_d = intv_q;
        if (!pause) begin
            if (f_rise) begin
                intv_d = ((intv_q >> 1) < STEP_LO) ? STEP_LO : intv_q >> 1;
            end else if (s_rise && !intv_q[STEP_W-1]) begin
                intv_d = intv_q << 1;
            end
        end

        blk_d   = '0;
        blink_d = 1'b1;
        if (reverse) begin
            blink_d = blink_q;
            if (blk_q == BLK_W'(BLINK_DIV - 1)) begin
                blk_d   = '0;
                blink_d = ~blink_q;
            end else begin
                blk_d = blk_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q  <= btn;
            rise_q  <= '0;
            pos_q   <= '0;
            len_q   <= LEN_W'(LEN_RST);
            intv_q  <= STEP_W'(STEP_INIT);
            stepc_q <= '0;
            blk_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            prev_q  <= btn;
            rise_q  <= rise_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            intv_q  <= intv_d;
            stepc_q <= stepc_d;
            blk_q   <= blk_d;
            blink_q <= blink_d;
        end
    end

    seg_scan_mux #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .glyphs_i (glyphs),
        .seg_n_o  (seg_n),
        .an_n_o   (an_n)
    );

    assign pos         = pos_q;
    assign len         = len_q;
    assign pause_led   = pause;
    assign reverse_led = reverse & (pause | blink_q);

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Scoreboard bench for seg_scroll_ctrl with small timing parameters.
// Expected values are queued at stimulus time and popped on DUT output.
module tb_seg_scroll_ctrl;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb0[$];
    sb_t sb1[$];
    int  n_vec = 0;
    int  n_bad = 0;

    logic        clk = 1'b0;
    logic        rst_n, pause, reverse;
    logic        faster, slower, longer, shorter;
    logic [31:0] glyphs;
    logic [7:0]  pos, len, seg_n;
    logic [3:0]  an_n;
    logic        pause_led, reverse_led;

    always #5 clk = ~clk;

    seg_scroll_ctrl #(
        .N_DIGITS  (4),
        .LEN_W     (8),
        .LEN_MAX   (255),
        .SCAN_DIV  (4),
        .STEP_W    (26),
        .STEP_INIT (16),
        .STEP_MIN  (4),
        .BLINK_DIV (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pause       (pause),
        .reverse     (reverse),
        .faster      (faster),
        .slower      (slower),
        .longer      (longer),
        .shorter     (shorter),
        .glyphs      (glyphs),
        .pos         (pos),
        .len         (len),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .pause_led   (pause_led),
        .reverse_led (reverse_led)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int s, input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        if (s == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic pop_chk(input int s, input logic [31:0] got);
        sb_t e;
        if (s == 0) begin
            if (sb0.size() == 0) begin
                chk("sb0_depth", sb0.size(), 1);
                return;
            end
            e = sb0.pop_front();
        end else begin
            if (sb1.size() == 0) begin
                chk("sb1_depth", sb1.size(), 1);
                return;
            end
            e = sb1.pop_front();
        end
        chk(e.tag, got, e.exp);
    endtask

    task automatic drain(input string tag);
        chk(tag, sb0.size() + sb1.size(), 0);
        sb0.delete();
        sb1.delete();
    endtask

    task automatic pulse(input logic [3:0] b);
        {faster, slower, longer, shorter} = b;
        repeat (2) @(negedge clk);
        {faster, slower, longer, shorter} = 4'b0;
        repeat (2) @(negedge clk);
    endtask

    // Cycles between two consecutive position changes; -1 on timeout.
    task automatic period(output int d);
        logic [7:0] p;
        bit         seen;
        d    = -1;
        seen = 0;
        p    = pos;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (pos !== p) begin
                seen = 1;
                break;
            end
        end
        if (!seen) return;
        p = pos;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (pos !== p) begin
                d = c;
                return;
            end
        end
    endtask

    task automatic check_period(input string tag, input int exp);
        int d;
        push(0, tag, exp);
        period(d);
        pop_chk(0, d);
    endtask

    task automatic check_pos_len(input string tag, input int p, input int l);
        push(0, {tag, "_pos"}, p);
        push(0, {tag, "_len"}, l);
        pop_chk(0, pos);
        pop_chk(0, len);
    endtask

    initial begin
        logic [3:0] last_an;
        logic [7:0] lastp;
        logic       lastl;
        int         since, sl, k;
        logic [7:0] an_exp [5];
        logic [7:0] sg_exp [5];

        rst_n   = 1'b0;
        pause   = 1'b1;
        reverse = 1'b0;
        {faster, slower, longer, shorter} = 4'b0;
        glyphs  = 32'h0403_0201;
        repeat (3) @(negedge clk);

        // Reset state
        push(0, "rst_pos", 0);
        push(0, "rst_len", 16);
        push(0, "rst_seg", 8'hFF);
        push(0, "rst_an", 4'hF);
        push(0, "rst_pled", 1);
        push(0, "rst_rled", 0);
        pop_chk(0, pos);
        pop_chk(0, len);
        pop_chk(0, seg_n);
        pop_chk(0, an_n);
        pop_chk(0, pause_led);
        pop_chk(0, reverse_led);

        // Scan order and per-digit segment alignment
        an_exp = '{8'hE, 8'hD, 8'hB, 8'h7, 8'hE};
        sg_exp = '{8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFE};
        for (int i = 0; i < 5; i++) begin
            push(0, $sformatf("scan_an%0d", i), an_exp[i]);
            push(0, $sformatf("scan_seg%0d", i), sg_exp[i]);
            if (i >= 2) push(0, $sformatf("scan_dwell%0d", i), 4);
        end
        rst_n   = 1'b1;
        last_an = 4'hF;
        since   = 0;
        k       = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            since++;
            if (an_n !== last_an) begin
                pop_chk(0, an_n);
                pop_chk(0, seg_n);
                if (k >= 2) pop_chk(0, since);
                last_an = an_n;
                since   = 0;
                k++;
                if (sb0.size() == 0) break;
            end
        end
        drain("scan_left");

        // Segment register follows glyph changes one cycle later
        glyphs = 32'h5555_5555;
        push(0, "seg_track", 8'hAA);
        @(negedge clk);
        pop_chk(0, seg_n);
        glyphs = 32'h0403_0201;

        // Paused: position held
        check_pos_len("paused_hold", 0, 16);

        // Forward auto-scroll, 17-cycle steps, wrap 15 -> 0
        pause = 1'b0;
        push(0, "run_pled", 0);
        pop_chk(0, pause_led);
        for (int i = 1; i <= 16; i++) begin
            push(0, $sformatf("fwd_pos%0d", i), i % 16);
            push(0, $sformatf("fwd_dt%0d", i), 17);
        end
        lastp = pos;
        since = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            since++;
            if (pos !== lastp) begin
                pop_chk(0, pos);
                pop_chk(0, since);
                lastp = pos;
                since = 0;
                if (sb0.size() == 0) break;
            end
        end
        drain("fwd_left");

        // Reverse: wrap 0 -> 15, indicator toggles every 8 cycles
        reverse = 1'b1;
        push(0, "rev_pos0", 15);
        push(0, "rev_dt0", 17);
        push(0, "rev_pos1", 14);
        push(0, "rev_dt1", 17);
        for (int i = 0; i < 4; i++) begin
            push(1, $sformatf("rled%0d", i), i % 2);
            push(1, $sformatf("rled_dt%0d", i), 8);
        end
        lastp = pos;
        lastl = 1'b1;
        since = 0;
        sl    = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            since++;
            sl++;
            if (pos !== lastp) begin
                pop_chk(0, pos);
                pop_chk(0, since);
                lastp = pos;
                since = 0;
            end
            if (reverse_led !== lastl) begin
                pop_chk(1, reverse_led);
                pop_chk(1, sl);
                lastl = reverse_led;
                sl    = 0;
            end
            if (sb0.size() == 0 && sb1.size() == 0) break;
        end
        drain("rev_left");
        reverse = 1'b0;

        // Interval: halve with clamp, double, and faster wins over slower
        pulse(4'b1000);
        check_period("intv_f1", 9);
        pulse(4'b1000);
        check_period("intv_f2", 5);
        pulse(4'b1000);
        check_period("intv_f3_clamp", 5);
        pulse(4'b0100);
        check_period("intv_s1", 9);
        pulse(4'b0100);
        check_period("intv_s2", 17);
        pulse(4'b1100);
        check_period("intv_both", 9);
        pulse(4'b0100);
        check_period("intv_s3", 17);

        // Manual stepping while paused
        pause = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(4'b1000);
        check_pos_len("man_back_wrap", 15, 16);
        pulse(4'b0100);
        check_pos_len("man_fwd_wrap", 0, 16);
        pulse(4'b0100);
        check_pos_len("man_fwd", 1, 16);
        slower = 1'b1;
        repeat (100) @(negedge clk);
        slower = 1'b0;
        repeat (2) @(negedge clk);
        check_pos_len("man_hold", 2, 16);
        pulse(4'b1100);
        check_pos_len("man_both", 2, 16);

        // Paused reverse indicator stays lit regardless of blink phase
        reverse = 1'b1;
        repeat (9) @(negedge clk);
        push(0, "rled_paused", 1);
        pop_chk(0, reverse_led);
        reverse = 1'b0;

        // Length edits and position clamp
        for (int i = 0; i < 8; i++) pulse(4'b0100);
        check_pos_len("len_start", 10, 16);
        for (int i = 0; i < 6; i++) pulse(4'b0001);
        check_pos_len("len_clamp", 9, 10);
        for (int i = 0; i < 7; i++) pulse(4'b0001);
        check_pos_len("len_floor", 3, 4);
        for (int i = 0; i < 260; i++) pulse(4'b0010);
        check_pos_len("len_ceil", 3, 255);

        // Mid-run reset with faster held through release
        pause = 1'b0;
        repeat (30) @(negedge clk);
        faster = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        check_pos_len("mid_rst", 0, 16);
        push(0, "mid_rst_seg", 8'hFF);
        push(0, "mid_rst_an", 4'hF);
        pop_chk(0, seg_n);
        pop_chk(0, an_n);
        rst_n = 1'b1;
        check_period("mid_rst_no_edge", 17);
        faster = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
